fp_compare_pipe: RTL and testbench
==================================

FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 Parameter WE, default 11, exponent width.
REQ-002 Parameter WF, default 18, fraction width.
REQ-003 Parameter LAT, default 2, pipeline depth in cycles; legal range 1..4.
REQ-004 Parameter TAGW, default 4, width of the sideband tag.
REQ-005 Derived data width W = WE+WF+3 in FloPoCo layout: [W-1:W-2] exn (00 zero, 01 normal, 10 inf, 11 NaN), [W-3] sign, [W-4:WF] exponent, [WF-1:0] fraction.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 in_valid  input  1  an operand pair is presented.
REQ-009 in_ready  output  1  the pair is accepted when in_valid and in_ready are both 1.
REQ-010 in_a, in_b  input  W each  operands A and B.
REQ-011 in_op  input  3  operation: 000 GE, 001 GT, 010 LE, 011 LT, 100 EQ, 101 NE, 110 MIN, 111 MAX (each predicate is A op B).
REQ-012 in_tag  input  TAGW  opaque tag, returned unchanged with the result.
REQ-013 out_valid  output  1  a result is presented.
REQ-014 out_ready  input  1  the result is consumed when out_valid and out_ready are both 1.
REQ-015 out_res  output  1  predicate result; 0 for MIN and MAX.
REQ-016 out_val  output  W  selected operand for MIN and MAX; 0 for predicate operations.
REQ-017 out_unord  output  1  at least one operand is NaN.
REQ-018 out_tag  output  TAGW  tag of the result.
REQ-019 nan_cnt  output  16  saturating count of unordered results consumed at the output.
REQ-020 cnt_clr  input  1  synchronous clear of nan_cnt.

Function
REQ-021 Pipeline: LAT register stages; all stages advance together when adv = out_ready OR NOT out_valid; in_ready SHALL equal adv (combinational).
REQ-022 An accepted pair SHALL appear at the outputs exactly LAT cycles later when adv stays 1; bubbles propagate as invalid stages.
REQ-023 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-024 While adv is 0, every stage and every output SHALL hold its value.
REQ-025 Stage 1 SHALL register the classification and the comparison; stages 2..LAT are delay registers only.
REQ-026 Ordering key = {rank, exponent, fraction}, with rank: zero=0, normal=1, inf=2. The exponent and fraction of zero and inf SHALL be ignored (treated as 0).
REQ-027 Signed order: a positive operand exceeds a negative one; equal sign compares keys, with the sense inverted for negative operands.
REQ-028 +0 and -0 SHALL compare equal.
REQ-029 For any NaN operand, out_unord SHALL be 1. GE/GT/LE/LT/EQ SHALL give 0 and NE SHALL give 1.
REQ-030 MIN/MAX with one NaN operand SHALL return the other operand; with two NaN operands, canonical NaN ({2'b11, all zeros}).
REQ-031 MIN/MAX with equal operands SHALL return A.
REQ-032 nan_cnt SHALL increment by 1 on each output handshake with out_unord=1, and SHALL saturate at 0xFFFF.
REQ-033 cnt_clr SHALL have priority over an increment in the same cycle; nan_cnt is 0 on the following cycle.

Reset
REQ-034 On rst, asynchronously: all stage valids 0; out_valid=0, out_res=0, out_val=0, out_unord=0, out_tag=0, nan_cnt=0.
REQ-035 Reset asserted mid-operation SHALL flush all in-flight pairs; no result of a pre-reset pair is ever emitted.
REQ-036 in_ready SHALL be 1 during and immediately after reset (pipeline empty).

Verification (WE=11, WF=18, LAT=2; 1.0=0x4FFC0000, 2.0=0x50000000, -1.0=0x6FFC0000, +0=0x00000000, -0=0x20000000, +inf=0x80000000, NaN=0xC0000000)
REQ-037 GE A=1.0 B=2.0 tag 3, out_ready=1 -> 2 cycles later out_res=0, out_tag=3; next cycle GE A=2.0 B=1.0 -> out_res=1.
REQ-038 EQ +0 vs -0 -> out_res=1; LT -1.0 vs +0 -> 1; GT +inf vs 2.0 -> 1; MIN 2.0 vs -1.0 -> out_val=0x6FFC0000.
REQ-039 GE NaN vs 1.0 -> out_res=0, out_unord=1, nan_cnt 0->1; NE -> out_res=1; MAX NaN vs 1.0 -> out_val=0x4FFC0000; MAX NaN vs NaN -> 0xC0000000.
REQ-040 Backpressure: 4 back-to-back pairs with tags 0..3, out_ready=0 for 3 cycles then 1 -> in_ready falls while output is stalled; tags emerge 0,1,2,3 exactly once each.
REQ-041 Reset: assert rst for 1 cycle with 2 pairs in flight -> out_valid=0 at once; no output within LAT+2 cycles after release without new input.
REQ-042 Saturation: preload nan_cnt to 0xFFFF via 65535 unordered results, then one more -> 0xFFFF held; cnt_clr coincident with an unordered handshake -> nan_cnt=0.

Source files
------------

// File: rtl/fp_compare_pipe.sv
// Purpose : pipelined FloPoCo-format comparator (GE/GT/LE/LT/EQ/NE predicates, MIN/MAX
//           selection) with a sideband tag and a saturating counter of unordered results.
// Latency : LAT cycles from input handshake to output, all stages advance together.
// Backpr. : in_ready = out_ready | ~out_valid; a stalled output freezes every stage.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_a, in_b (W bits), in_op (3), in_tag (TAGW)
//   out_valid/out_ready result handshake; out_res, out_val (W), out_unord, out_tag (TAGW)
//   nan_cnt (16)        saturating count of consumed unordered results
//   cnt_clr             synchronous clear of nan_cnt, wins over an increment
//
// Operand layout (W = WE+WF+3): [W-1:W-2] exn (00 zero, 01 normal, 10 inf, 11 NaN),
// [W-3] sign, [W-4:WF] exponent, [WF-1:0] fraction. LAT must lie in 1..4.

module fp_compare_pipe #(
  parameter int WE   = 11,
  parameter int WF   = 18,
  parameter int LAT  = 2,
  parameter int TAGW = 4,
  localparam int W   = WE + WF + 3,
  localparam int KW  = WE + WF + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [2:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_res,
  output logic [W-1:0]    out_val,
  output logic            out_unord,
  output logic [TAGW-1:0] out_tag,
  output logic [15:0]     nan_cnt,
  input  logic            cnt_clr
);

  localparam logic [2:0] OP_GE  = 3'b000;
  localparam logic [2:0] OP_GT  = 3'b001;
  localparam logic [2:0] OP_LE  = 3'b010;
  localparam logic [2:0] OP_LT  = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_NE  = 3'b101;
  localparam logic [2:0] OP_MIN = 3'b110;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  // Canonical quiet NaN returned when both MIN/MAX operands are NaN.
  localparam logic [W-1:0] CANON_NAN = {EXN_NAN, {(W-2){1'b0}}};

  // Ordering key {rank, exponent, fraction}. Zero and inf carry no magnitude
  // information, so their exponent/fraction fields are forced to zero here;
  // NaN gets key 0 too but is never ordered.
  function automatic logic [KW-1:0] f_key(input logic [W-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    case (x[W-1:W-2])
      EXN_NORM: k = {2'b01, x[W-4:0]};
      EXN_INF:  k = {2'b10, {(WE+WF){1'b0}}};
      default:  k = '0;
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------------
  // Classification and comparison (feeds stage 1)
  // ---------------------------------------------------------------------
  logic [1:0]    w_exn_a, w_exn_b;
  logic          w_sgn_a, w_sgn_b;
  logic [KW-1:0] w_key_a, w_key_b;
  logic          w_nan_a, w_nan_b, w_unord;
  logic          w_zero_both;
  logic          w_eq, w_lt;
  logic [W-1:0]  w_min, w_max;
  logic          w_res;
  logic [W-1:0]  w_val;

  assign w_exn_a     = in_a[W-1:W-2];
  assign w_exn_b     = in_b[W-1:W-2];
  assign w_sgn_a     = in_a[W-3];
  assign w_sgn_b     = in_b[W-3];
  assign w_key_a     = f_key(in_a);
  assign w_key_b     = f_key(in_b);
  assign w_nan_a     = (w_exn_a == EXN_NAN);
  assign w_nan_b     = (w_exn_b == EXN_NAN);
  assign w_unord     = w_nan_a | w_nan_b;
  assign w_zero_both = (w_exn_a == EXN_ZERO) && (w_exn_b == EXN_ZERO);

  // +0 and -0 are equal regardless of sign. Any other pair is equal only
  // when both sign and key match.
  assign w_eq = w_zero_both || ((w_sgn_a == w_sgn_b) && (w_key_a == w_key_b));

  // A < B: with different signs the negative one is smaller (a lone zero
  // still orders correctly since its key is 0); with equal signs the key
  // comparison flips for negative operands.
  always_comb begin
    w_lt = 1'b0;
    if (!w_eq) begin
      if (w_sgn_a != w_sgn_b) w_lt = w_sgn_a;
      else if (w_sgn_a)       w_lt = (w_key_a > w_key_b);
      else                    w_lt = (w_key_a < w_key_b);
    end
  end

  // MIN/MAX: a single NaN yields the other operand, ties yield A.
  always_comb begin
    w_min = in_a;
    w_max = in_a;
    if (w_nan_a && w_nan_b) begin
      w_min = CANON_NAN;
      w_max = CANON_NAN;
    end else if (w_nan_a) begin
      w_min = in_b;
      w_max = in_b;
    end else if (w_nan_b) begin
      w_min = in_a;
      w_max = in_a;
    end else begin
      w_min = (w_lt || w_eq) ? in_a : in_b;
      w_max = w_lt ? in_b : in_a;
    end
  end

  // Predicates are false whenever unordered, except NE which is true.
  always_comb begin
    w_res = 1'b0;
    w_val = '0;
    case (in_op)
      OP_GE:   w_res = ~w_unord & ~w_lt;
      OP_GT:   w_res = ~w_unord & ~w_lt & ~w_eq;
      OP_LE:   w_res = ~w_unord & (w_lt | w_eq);
      OP_LT:   w_res = ~w_unord & w_lt;
      OP_EQ:   w_res = ~w_unord & w_eq;
      OP_NE:   w_res = w_unord | ~w_eq;
      OP_MIN:  w_val = w_min;
      default: w_val = w_max;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline: stage 0 captures the comparison, later stages only delay it.
  // Bubbles carry zeroed payload so idle outputs read as 0.
  // ---------------------------------------------------------------------
  logic [LAT-1:0]           r_vld;
  logic [LAT-1:0]           r_res;
  logic [LAT-1:0][W-1:0]    r_val;
  logic [LAT-1:0]           r_unord;
  logic [LAT-1:0][TAGW-1:0] r_tag;
  logic                     w_adv;

  assign w_adv    = out_ready | ~r_vld[LAT-1];
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_res   <= '0;
      r_val   <= '0;
      r_unord <= '0;
      r_tag   <= '0;
    end else if (w_adv) begin
      r_vld[0]   <= in_valid;
      r_res[0]   <= in_valid & w_res;
      r_val[0]   <= in_valid ? w_val : '0;
      r_unord[0] <= in_valid & w_unord;
      r_tag[0]   <= in_valid ? in_tag : '0;
      for (int k = 1; k < LAT; k++) begin
        r_vld[k]   <= r_vld[k-1];
        r_res[k]   <= r_res[k-1];
        r_val[k]   <= r_val[k-1];
        r_unord[k] <= r_unord[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign out_res   = r_res[LAT-1];
  assign out_val   = r_val[LAT-1];
  assign out_unord = r_unord[LAT-1];
  assign out_tag   = r_tag[LAT-1];

  // ---------------------------------------------------------------------
  // Unordered-result counter, counts consumed results only.
  // ---------------------------------------------------------------------
  logic [15:0] r_nan_cnt;
  logic        w_nan_hs;

  assign w_nan_hs = out_valid & out_ready & out_unord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nan_cnt <= '0;
    end else if (cnt_clr) begin
      r_nan_cnt <= '0;
    end else if (w_nan_hs && (r_nan_cnt != 16'hFFFF)) begin
      r_nan_cnt <= r_nan_cnt + 16'd1;
    end
  end

  assign nan_cnt = r_nan_cnt;

endmodule

// File: tb/tb_fp_compare_pipe.sv
module tb_fp_compare_pipe;
  localparam int WE = 11, WF = 18, LAT = 2, TAGW = 4;
  localparam int W  = WE + WF + 3;

  localparam logic [W-1:0] ONE   = 32'h4FFC0000;
  localparam logic [W-1:0] TWO   = 32'h50000000;
  localparam logic [W-1:0] MONE  = 32'h6FFC0000;
  localparam logic [W-1:0] PZERO = 32'h00000000;
  localparam logic [W-1:0] NZERO = 32'h20000000;
  localparam logic [W-1:0] PINF  = 32'h80000000;
  localparam logic [W-1:0] NINF  = 32'hA0000000;
  localparam logic [W-1:0] QNAN  = 32'hC0000000;
  localparam logic [W-1:0] Z     = 32'h00000000;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [W-1:0]    in_a, in_b;
  logic [2:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, out_ready;
  logic            out_res, out_unord;
  logic [W-1:0]    out_val;
  logic [TAGW-1:0] out_tag;
  logic [15:0]     nan_cnt;
  logic            cnt_clr;

  always #5 clk = ~clk;

  fp_compare_pipe #(.WE(WE), .WF(WF), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_val(out_val), .out_unord(out_unord), .out_tag(out_tag),
    .nan_cnt(nan_cnt), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [2:0]      op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [TAGW-1:0] tag;
    logic            res;
    logic [W-1:0]    val;
    logic            unord;
  } vec_t;

  typedef struct {
    logic            res;
    logic [W-1:0]    val;
    logic            unord;
    logic [TAGW-1:0] tag;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_hs  = 0;
  int   nan_model = 0;
  exp_t exp_q[$];
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Map an ordered operand onto the signed number line: zero sits at 0 whatever
  // its sign, normals are 1 + their {exponent,fraction} magnitude, infinities
  // lie beyond every normal.
  function automatic longint ord_of(input logic [W-1:0] x);
    longint mag;
    case (x[W-1:W-2])
      2'b00:   mag = 0;
      2'b01:   mag = 1 + longint'(x[W-4:0]);
      default: mag = longint'(1) << (WE + WF + 1);
    endcase
    return x[W-3] ? -mag : mag;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TAGW-1:0] tag);
    exp_t   e;
    bit     na, nb;
    longint oa, ob;
    na = (a[W-1:W-2] == 2'b11);
    nb = (b[W-1:W-2] == 2'b11);
    e.unord = na || nb;
    e.tag = tag;
    e.res = 1'b0;
    e.val = '0;
    oa = na ? 0 : ord_of(a);
    ob = nb ? 0 : ord_of(b);
    case (op)
      3'd0: e.res = !e.unord && (oa >= ob);
      3'd1: e.res = !e.unord && (oa >  ob);
      3'd2: e.res = !e.unord && (oa <= ob);
      3'd3: e.res = !e.unord && (oa <  ob);
      3'd4: e.res = !e.unord && (oa == ob);
      3'd5: e.res = e.unord || (oa != ob);
      default: begin
        if (na && nb)  e.val = QNAN;
        else if (na)   e.val = b;
        else if (nb)   e.val = a;
        else if (op == 3'd6) e.val = (oa <= ob) ? a : b;
        else                 e.val = (oa >= ob) ? a : b;
      end
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] x;
    int sel;
    sel = $urandom_range(0, 9);
    x = W'($urandom);
    if (sel <= 5) begin
      x[W-1:W-2] = 2'b01;
      x[W-4:WF]  = WE'($urandom_range(1022, 1025));
      x[WF-1:0]  = WF'($urandom_range(0, 3));
    end else if (sel <= 7) begin
      x[W-1:W-2] = 2'b00;
    end else if (sel == 8) begin
      x[W-1:W-2] = 2'b10;
    end else begin
      x[W-1:W-2] = 2'b11;
    end
    return x;
  endfunction

  // One clock cycle with scoreboarding: inputs already driven by the caller.
  task automatic step();
    bit   acc, hs;
    exp_t e;
    #2;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    e.unord = 1'b0;
    if (hs) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        chk("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tag", out_tag, e.tag);
        chk("sb_res", out_res, e.res);
        chk("sb_val", out_val, e.val);
        chk("sb_unord", out_unord, e.unord);
      end
    end
    if (acc) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
    if (cnt_clr) nan_model = 0;
    else if (hs && e.unord && nan_model < 65535) nan_model++;
    @(posedge clk);
    #1;
    chk("nan_cnt_track", nan_cnt, nan_model);
  endtask

  initial begin
    bit saw_block;
    int next;
    rst = 1'b1;
    in_valid = 0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1; cnt_clr = 0;

    tbl[0]  = '{3'd0, ONE,   TWO,   4'd3,  1'b0, Z,     1'b0};
    tbl[1]  = '{3'd0, TWO,   ONE,   4'd4,  1'b1, Z,     1'b0};
    tbl[2]  = '{3'd4, PZERO, NZERO, 4'd5,  1'b1, Z,     1'b0};
    tbl[3]  = '{3'd3, MONE,  PZERO, 4'd6,  1'b1, Z,     1'b0};
    tbl[4]  = '{3'd1, PINF,  TWO,   4'd7,  1'b1, Z,     1'b0};
    tbl[5]  = '{3'd6, TWO,   MONE,  4'd8,  1'b0, MONE,  1'b0};
    tbl[6]  = '{3'd0, QNAN,  ONE,   4'd9,  1'b0, Z,     1'b1};
    tbl[7]  = '{3'd5, QNAN,  ONE,   4'd10, 1'b1, Z,     1'b1};
    tbl[8]  = '{3'd7, QNAN,  ONE,   4'd11, 1'b0, ONE,   1'b1};
    tbl[9]  = '{3'd7, QNAN,  QNAN,  4'd12, 1'b0, QNAN,  1'b1};
    tbl[10] = '{3'd6, NZERO, PZERO, 4'd13, 1'b0, NZERO, 1'b0};
    tbl[11] = '{3'd2, MONE,  MONE,  4'd14, 1'b1, Z,     1'b0};
    tbl[12] = '{3'd7, NINF,  MONE,  4'd15, 1'b0, MONE,  1'b0};
    tbl[13] = '{3'd3, ONE,   TWO,   4'd1,  1'b1, Z,     1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_unord", out_unord, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_nan_cnt", nan_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors, one at a time, exact latency checked
    foreach (tbl[i]) begin
      in_valid = 1; in_op = tbl[i].op; in_a = tbl[i].a; in_b = tbl[i].b; in_tag = tbl[i].tag;
      @(posedge clk); #1;
      in_valid = 0;
      for (int k = 1; k < LAT; k++) begin
        chk("lat_early_valid", out_valid, 0);
        @(posedge clk); #1;
      end
      chk("vec_valid", out_valid, 1);
      chk($sformatf("vec%0d_res", i), out_res, tbl[i].res);
      chk($sformatf("vec%0d_val", i), out_val, tbl[i].val);
      chk($sformatf("vec%0d_unord", i), out_unord, tbl[i].unord);
      chk($sformatf("vec%0d_tag", i), out_tag, tbl[i].tag);
      if (tbl[i].unord) nan_model++;
      @(posedge clk); #1;
      chk("vec_drained", out_valid, 0);
      chk("vec_nan_cnt", nan_cnt, nan_model);
    end

    // Backpressure: 4 pairs, output stalled for 3 cycles
    saw_block = 0;
    next = 0;
    n_hs = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 3);
      in_valid  = (next < 4);
      in_op = 3'd1; in_a = TWO; in_b = ONE; in_tag = TAGW'(next);
      #1;
      if (!out_ready && !in_ready) saw_block = 1;
      if (in_valid && in_ready) next++;
      step();
      #0;
    end
    in_valid = 0;
    chk("bp_in_ready_fell", saw_block, 1);
    chk("bp_outputs", n_hs, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      in_op  = 3'($urandom_range(0, 7));
      in_a   = rnd_operand();
      in_b   = ($urandom_range(0, 4) == 0) ? in_a : rnd_operand();
      in_tag = TAGW'($urandom);
      step();
    end
    in_valid = 0; cnt_clr = 0; out_ready = 1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    chk("rand_drain_empty", exp_q.size(), 0);

    // Reset with two pairs in flight
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_op = 3'd0; in_a = ONE; in_b = ONE; in_tag = TAGW'(k);
      step();
    end
    in_valid = 0;
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_nan_cnt", nan_cnt, 0);
    exp_q.delete();
    nan_model = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      chk("postrst_no_output", out_valid, 0);
    end

    // Saturation of nan_cnt
    in_valid = 1; in_op = 3'd0; in_a = QNAN; in_b = ONE; in_tag = '0; out_ready = 1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("sat_reach_ffff", nan_cnt, 16'hFFFF);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("sat_hold_ffff", nan_cnt, 16'hFFFF);

    // Clear coincident with an unordered handshake
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
    end
    chk("clr_out_valid", out_valid, 1);
    chk("clr_out_unord", out_unord, 1);
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    chk("clr_wins", nan_cnt, 0);
    @(posedge clk); #1;
    chk("clr_stays", nan_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
